// File: rtl/dsp_filter_pkg.sv
// Shared constants for the binary-weighted FIR family and its inverse.
// Tap shifts describe the forward filter; FB_SHIFT is the equaliser pole weight.
package dsp_filter_pkg;
    localparam int F_DEFAULT = 8;
    localparam int H1        = 0;
    localparam int H2        = 1;
    localparam int H3        = 2;
    localparam int H4        = 3;
    localparam int FB_SHIFT  = 4;

    function automatic int round_offset(input int f);
        return 1 << (f - 1);
    endfunction
endpackage

// File: rtl/dsp_deconv_filter_if.sv
// Stream bus for the deconvolution filter: y input side, x output side, plus flush.
interface dsp_deconv_filter_if #(
    parameter int Y_W = 10,
    parameter int X_W = 8
);
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [Y_W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [X_W-1:0] out_data;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dsp_deconv_hist.sv
// History for the equaliser recursion: last input y1 and four unrounded outputs.
// Shifts only when en is high; flush clears everything on the next edge.
module dsp_deconv_hist #(
    parameter int Y_W = 10,
    parameter int IW  = 21
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 en,
    input  logic [Y_W-1:0]       y_in,
    input  logic signed [IW-1:0] x_in,
    output logic [Y_W-1:0]       y1,
    output logic signed [IW-1:0] x4
);
    logic [Y_W-1:0]       y1_reg;
    logic signed [IW-1:0] x_reg [0:3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y1_reg <= '0;
            for (int i = 0; i < 4; i++) x_reg[i] <= '0;
        end else if (flush) begin
            y1_reg <= '0;
            for (int i = 0; i < 4; i++) x_reg[i] <= '0;
        end else if (en) begin
            y1_reg   <= y_in;
            x_reg[0] <= x_in;
            for (int i = 1; i < 4; i++) x_reg[i] <= x_reg[i-1];
        end
    end

    assign y1 = y1_reg;
    assign x4 = x_reg[3];
endmodule

// File: rtl/dsp_deconv_filter.sv
// Inverse of the 1 + z^-1/2 + z^-2/4 + z^-3/8 FIR: x[n] = y[n] - y[n-1]/2 + x[n-4]/16.
// Optional macro DSP_DECONV_SAT_CNT_EN adds a 16-bit saturation event counter.
module dsp_deconv_filter
    import dsp_filter_pkg::*;
#(
    parameter int Y_W = 10,
    parameter int X_W = 8,
    parameter int F   = F_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    dsp_deconv_filter_if.slave   bus
`ifdef DSP_DECONV_SAT_CNT_EN
    ,
    output logic [15:0]          sat_cnt
`endif
);
    localparam int IW = Y_W + F + 3;
    localparam logic signed [IW:0] ACC_MAX = {2'b00, {(IW-1){1'b1}}};
    localparam logic signed [IW:0] ACC_MIN = {2'b11, {(IW-1){1'b0}}};
    localparam logic signed [IW:0] RND     = (IW+1)'(round_offset(F));
    localparam logic signed [IW:0] OUT_MAX = (IW+1)'((1 << X_W) - 1);

    logic                 accept;
    logic [Y_W-1:0]       y1;
    logic signed [IW-1:0] x4;
    logic signed [IW:0]   y_term, y1_term, x4_term, acc_wide, rounded;
    logic signed [IW-1:0] acc_clamped;
    logic                 sat_lo, sat_hi;
    logic [X_W-1:0]       r_sat;
    logic                 out_valid_reg;
    logic [X_W-1:0]       out_data_reg;

    assign bus.in_ready = !bus.flush && (!out_valid_reg || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        y_term   = $signed({{(IW+1-Y_W){1'b0}}, bus.in_data}) <<< F;
        y1_term  = $signed({{(IW+1-Y_W){1'b0}}, y1}) <<< (F - H2);
        x4_term  = $signed({x4[IW-1], x4}) >>> FB_SHIFT;
        acc_wide = y_term - y1_term + x4_term;

        acc_clamped = acc_wide[IW-1:0];
        if (acc_wide > ACC_MAX)      acc_clamped = ACC_MAX[IW-1:0];
        else if (acc_wide < ACC_MIN) acc_clamped = ACC_MIN[IW-1:0];

        // Round half up on the clamped value, then saturate to the unsigned output range.
        rounded = ($signed({acc_clamped[IW-1], acc_clamped}) + RND) >>> F;
        sat_lo  = rounded[IW];
        sat_hi  = !rounded[IW] && (rounded > OUT_MAX);
        r_sat   = rounded[X_W-1:0];
        if (sat_lo)      r_sat = '0;
        else if (sat_hi) r_sat = '1;
    end

    dsp_deconv_hist #(
        .Y_W (Y_W),
        .IW  (IW)
    ) u_hist (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.flush),
        .en    (accept),
        .y_in  (bus.in_data),
        .x_in  (acc_clamped),
        .y1    (y1),
        .x4    (x4)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (bus.flush) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= r_sat;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;

`ifdef DSP_DECONV_SAT_CNT_EN
    logic [15:0] sat_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sat_cnt_reg <= '0;
        else if (bus.flush)
            sat_cnt_reg <= '0;
        else if (accept && (sat_lo || sat_hi) && (sat_cnt_reg != 16'hFFFF))
            sat_cnt_reg <= sat_cnt_reg + 16'd1;
    end

    assign sat_cnt = sat_cnt_reg;
`endif
endmodule

// File: tb/tb_dsp_deconv_filter.sv
// Directed bench for dsp_deconv_filter: vector table plus backpressure, flush and reset sequences.
module tb_dsp_deconv_filter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dsp_deconv_filter_if #(.Y_W(10), .X_W(8)) bus ();

`ifdef DSP_DECONV_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    dsp_deconv_filter #(.Y_W(10), .X_W(8), .F(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus)
`ifdef DSP_DECONV_SAT_CNT_EN
        ,
        .sat_cnt (sat_cnt)
`endif
    );

    typedef struct {
        bit          flush_before;
        logic [9:0]  y;
        logic [7:0]  exp;
        int          sat;
        string       name;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end else begin
            $display("ok   %s: %0d", name, actual);
        end
    endtask

    task automatic send(input string name, input logic [9:0] y, input logic [7:0] exp);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = y;
        bus.out_ready = 1'b1;
        #1;
        check({name, " in_ready"}, int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({name, " out_valid"}, int'(bus.out_valid), 1);
        check({name, " out_data"}, int'(bus.out_data), int'(exp));
    endtask

    task automatic do_flush();
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush out_valid", int'(bus.out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 10'd8,    8'd8,   0, "imp0"};
        vecs[1]  = '{1'b0, 10'd4,    8'd0,   0, "imp1"};
        vecs[2]  = '{1'b0, 10'd2,    8'd0,   0, "imp2"};
        vecs[3]  = '{1'b0, 10'd1,    8'd0,   0, "imp3"};
        vecs[4]  = '{1'b0, 10'd0,    8'd0,   0, "imp4"};
        vecs[5]  = '{1'b0, 10'd0,    8'd0,   0, "imp5"};
        vecs[6]  = '{1'b0, 10'd0,    8'd0,   0, "imp6"};
        vecs[7]  = '{1'b1, 10'd16,   8'd16,  0, "step0"};
        vecs[8]  = '{1'b0, 10'd24,   8'd16,  0, "step1"};
        vecs[9]  = '{1'b0, 10'd28,   8'd16,  0, "step2"};
        vecs[10] = '{1'b0, 10'd30,   8'd16,  0, "step3"};
        vecs[11] = '{1'b0, 10'd30,   8'd16,  0, "step4"};
        vecs[12] = '{1'b0, 10'd30,   8'd16,  0, "step5"};
        vecs[13] = '{1'b1, 10'd0,    8'd0,   0, "satA0"};
        vecs[14] = '{1'b0, 10'd1023, 8'd255, 1, "satA1"};
        vecs[15] = '{1'b1, 10'd1023, 8'd255, 1, "satB0"};
        vecs[16] = '{1'b0, 10'd0,    8'd0,   2, "satB1"};
        vecs[17] = '{1'b1, 10'd1023, 8'd255, 1, "satC0"};

        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset out_data", int'(bus.out_data), 0);
        check("reset in_ready", int'(bus.in_ready), 1);
`ifdef DSP_DECONV_SAT_CNT_EN
        check("reset sat_cnt", int'(sat_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].flush_before) do_flush();
            send(vecs[i].name, vecs[i].y, vecs[i].exp);
`ifdef DSP_DECONV_SAT_CNT_EN
            check({vecs[i].name, " sat_cnt"}, int'(sat_cnt), vecs[i].sat);
`endif
        end

        // Backpressure in the middle of the step
        do_flush();
`ifdef DSP_DECONV_SAT_CNT_EN
        check("flush sat_cnt", int'(sat_cnt), 0);
`endif
        send("bp0", 10'd16, 8'd16);
        send("bp1", 10'd24, 8'd16);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 10'd28;
        #1;
        check("bp stall in_ready", int'(bus.in_ready), 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("bp stall out_valid", int'(bus.out_valid), 1);
            check("bp stall out_data", int'(bus.out_data), 16);
            check("bp stall in_ready", int'(bus.in_ready), 0);
        end
        send("bp2", 10'd28, 8'd16);
        send("bp3", 10'd30, 8'd16);
        send("bp4", 10'd30, 8'd16);

        // Flush mid-impulse behaves like a fresh start
        do_flush();
        send("fl0", 10'd8, 8'd8);
        send("fl1", 10'd4, 8'd0);
        do_flush();
        send("fl2", 10'd8, 8'd8);
        send("fl3", 10'd4, 8'd0);
        send("fl4", 10'd2, 8'd0);
        send("fl5", 10'd1, 8'd0);

        // Flush blocks a simultaneous valid sample
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 10'd1023;
        bus.out_ready = 1'b1;
        #1;
        check("flush+valid in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush+valid out_valid", int'(bus.out_valid), 0);
        send("fv0", 10'd8, 8'd8);
        send("fv1", 10'd4, 8'd0);

        // Asynchronous reset between edges while streaming
        do_flush();
        send("ar0", 10'd16, 8'd16);
        send("ar1", 10'd24, 8'd16);
        #2;
        rst = 1'b0;
        #1;
        check("async rst out_valid", int'(bus.out_valid), 0);
        check("async rst out_data", int'(bus.out_data), 0);
        @(negedge clk);
        rst = 1'b1;
        send("rs0", 10'd16, 8'd16);
        send("rs1", 10'd24, 8'd16);
        send("rs2", 10'd28, 8'd16);
        send("rs3", 10'd30, 8'd16);
        send("rs4", 10'd30, 8'd16);
        send("rs5", 10'd30, 8'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dsp_deconv_filter.md
Name: dsp_deconv_filter

Overview:
- Inverse (equaliser) of the team's 4-tap binary-weighted FIR, whose forward response is H(z) = 1 + 0.5z^-1 + 0.25z^-2 + 0.125z^-3.
- Takes the filtered stream y and reconstructs the original sample stream x. It sits on the receive side of the filter path.
- Recursion used: x[n] = y[n] - 0.5*y[n-1] + (1/16)*x[n-4]. The pole radius is 0.5, so the recursion is stable.
- Streaming valid/ready on both sides, one registered output stage, and a synchronous history flush.

Parameters:
- Y_W, 10: input width, unsigned. Forward FIR output growth is covered for an 8-bit x.
- X_W, 8: output width, unsigned. Output is rounded and saturated.
- F, 8: fractional bits kept in the feedback history. Must be >= 4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all history and the output stage.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  Y_W  filtered sample y[n].
- out_valid  out  1  out_data holds a reconstructed sample.
- out_ready  in  1  sink accepts out_data this cycle.
- out_data  out  X_W  reconstructed x[n].

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. Reset clears y1, x1..x4, out_valid and out_data to 0.
- Internal width: IW = Y_W+F+3, signed.
- History registers:
  - y1: previous y, Y_W bits.
  - x1..x4: previous unrounded x values, IW bits.
- Accumulator, combinational on in_data: acc = (in_data<<F) - (y1<<(F-1)) + (x4>>>4), computed at IW+1 bits. The result is clamped to the signed IW range before use.
- Output conversion: r = (acc + 2^(F-1)) >>> F (round half up). r<0 gives 0; r>2^X_W-1 gives 2^X_W-1.
- Feedback path: the unrounded, clamped acc is fed back, not the saturated output.
- in_ready = !flush && (!out_valid || out_ready). There are no combinational paths other than through out_ready.
- Accept happens when in_valid && in_ready. On accept:
  - y1 <= in_data;
  - x4<=x3, x3<=x2, x2<=x1, x1<=acc;
  - out_data <= r; out_valid <= 1.
- Latency: exactly 1 cycle from accept to out_valid.
- Consume without accept (out_valid && out_ready): out_valid <= 0. out_data holds its value.
- Accept and consume in the same cycle: out_valid stays 1 and out_data takes the new value. Full throughput is one sample per cycle.
- Stall (out_valid && !out_ready): out_data and out_valid hold, in_ready=0, and history is frozen.
- History advances only on accepted samples. Idle cycles never shift it.
- flush=1: the next edge clears all history and out_valid, and any pending output is dropped. Flush takes priority over a simultaneous accept, which is blocked because in_ready=0.
- Reset mid-stream: everything clears immediately. The first post-reset sample is treated as n=0.

Optional Feature:
- Macro: DSP_DECONV_SAT_CNT_EN.
- When defined:
  - Adds output port sat_cnt, 16 bits.
  - The counter increments on every accept where r needed clamping, low or high.
  - It saturates at 0xFFFF.
  - It is cleared by rst or flush.
- When undefined: the port and logic are absent and the remaining behaviour is identical.

Decomposition:
- Package dsp_filter_pkg contains:
  - default F;
  - tap shift constants (H1..H4 = 0..3 for the forward filter, feedback shift 4);
  - the rounding-offset function.
- One sub-module: dsp_deconv_hist. It is the enable-gated shift register holding y1 and x1..x4 with flush clear. Arithmetic, the handshake and saturation stay in the top.

Test Plan:
- Impulse: y = 8,4,2,1,0,0,0 with out_ready=1 -> out_data = 8,0,0,0,0,0,0. Each output follows its accept by 1 cycle.
- Step: y = 16,24,28,30,30,30 -> out_data = 16,16,16,16,16,16.
- Backpressure: hold out_ready=0 for 3 cycles mid-stream of the step.
  - in_ready=0 and out_data stays frozen.
  - After release the sequence continues as 16,16 with no loss or duplication.
- Saturation:
  - y = 0,1023 then y = 1023,0 -> second output is 0 (negative clamp).
  - A single y=1023 -> 255 (high clamp).
  - With the macro on, sat_cnt increments once per clamp.
- Flush: drive flush after y=8,4 of the impulse, then feed y=8,4,2,1 -> outputs 8,0,0,0, identical to a fresh start. Flush asserted together with in_valid=1 -> sample not accepted.
- Async reset: assert rst low between edges during streaming -> out_valid=0 and out_data=0 immediately. Step replay afterwards gives 16,16,...
